// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag-vector layout for the pipelined ALU.
package alu_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR = 3'b111;

  localparam int unsigned FLAG_CARRY    = 0;
  localparam int unsigned FLAG_ZERO     = 1;
  localparam int unsigned FLAG_NEGATIVE = 2;
  localparam int unsigned FLAG_OVERFLOW = 3;
  localparam int unsigned NUM_FLAGS     = 4;

endpackage

// File: rtl/alu_if.sv
// Operand and result handshakes of alu_pipe; master is the sequencer/sink side.
interface alu_if
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [OP_W-1:0]  op;
  logic             use_acc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             negative;
  logic             overflow;
  logic [WIDTH-1:0] acc;

  modport master (
    output in_valid, a, b, op, use_acc, out_ready,
    input  in_ready, out_valid, result, carry, zero, negative, overflow, acc
  );

  modport slave (
    input  in_valid, a, b, op, use_acc, out_ready,
    output in_ready, out_valid, result, carry, zero, negative, overflow, acc
  );

endinterface

// File: rtl/alu_core.sv
// Purely combinational WIDTH-bit ALU: result plus carry/zero/negative/overflow.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  logic [WIDTH:0] ext;

  always_comb begin
    ext      = '0;
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_ADD: begin
        ext      = {1'b0, a} + {1'b0, b};
        result   = ext[WIDTH-1:0];
        carry    = ext[WIDTH];
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        // Top bit of the widened difference is the unsigned borrow.
        ext      = {1'b0, a} - {1'b0, b};
        result   = ext[WIDTH-1:0];
        carry    = ext[WIDTH];
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_NOT:  result = ~a;
      OP_SHL: begin
        result = {a[WIDTH-2:0], 1'b0};
        carry  = a[WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[WIDTH-1:1]};
        carry  = a[0];
      end
      default: result = '0;
    endcase
  end

  assign zero     = (result == '0);
  assign negative = result[WIDTH-1];

endmodule

// File: rtl/alu_pipe.sv
// Two-stage ALU pipeline: S1 captures operands, S2 holds the computed result and flags.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter bit          ACC_EN = 1'b1
) (
  input logic   clk,
  input logic   rst,
  alu_if.slave  bus
);

  logic                 s1_valid_q;
  logic [WIDTH-1:0]     s1_a_q;
  logic [WIDTH-1:0]     s1_b_q;
  logic [OP_W-1:0]      s1_op_q;
  logic                 s1_use_acc_q;
  logic                 s2_valid_q;
  logic [WIDTH-1:0]     s2_result_q;
  logic [NUM_FLAGS-1:0] s2_flags_q;
  logic [WIDTH-1:0]     acc_q;

  logic                 s2_adv;
  logic                 s1_adv;
  logic                 in_fire;
  logic [WIDTH-1:0]     eff_a;
  logic [WIDTH-1:0]     core_result;
  logic [NUM_FLAGS-1:0] core_flags;

  assign s2_adv       = !s2_valid_q || bus.out_ready;
  assign s1_adv       = s1_valid_q && s2_adv;
  assign bus.in_ready = !rst && (!s1_valid_q || s2_adv);
  assign in_fire      = bus.in_valid && bus.in_ready;

  // acc is sampled as the beat enters S2, so a chained op sees its predecessor's result.
  assign eff_a = (ACC_EN && s1_use_acc_q) ? acc_q : s1_a_q;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a        (eff_a),
    .b        (s1_b_q),
    .op       (s1_op_q),
    .result   (core_result),
    .carry    (core_flags[FLAG_CARRY]),
    .zero     (core_flags[FLAG_ZERO]),
    .negative (core_flags[FLAG_NEGATIVE]),
    .overflow (core_flags[FLAG_OVERFLOW])
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_op_q      <= '0;
      s1_use_acc_q <= 1'b0;
    end else if (in_fire) begin
      s1_valid_q   <= 1'b1;
      s1_a_q       <= bus.a;
      s1_b_q       <= bus.b;
      s1_op_q      <= bus.op;
      s1_use_acc_q <= bus.use_acc;
    end else if (s1_adv) begin
      s1_valid_q   <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_flags_q  <= '0;
    end else if (s1_adv) begin
      s2_valid_q  <= 1'b1;
      s2_result_q <= core_result;
      s2_flags_q  <= core_flags;
    end else if (bus.out_ready) begin
      s2_valid_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (ACC_EN && s1_adv) begin
      acc_q <= core_result;
    end
  end

  assign bus.out_valid = s2_valid_q;
  assign bus.result    = s2_result_q;
  assign bus.carry     = s2_flags_q[FLAG_CARRY];
  assign bus.zero      = s2_flags_q[FLAG_ZERO];
  assign bus.negative  = s2_flags_q[FLAG_NEGATIVE];
  assign bus.overflow  = s2_flags_q[FLAG_OVERFLOW];
  assign bus.acc       = acc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: 4-bit, 8-bit and accumulator-disabled instances on one clock.
module tb_alu_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_if #(.WIDTH(4)) bus4 ();
  alu_if #(.WIDTH(8)) bus8 ();
  alu_if #(.WIDTH(8)) busn ();

  alu_pipe #(.WIDTH(4), .ACC_EN(1'b1)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
  alu_pipe #(.WIDTH(8), .ACC_EN(1'b1)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  alu_pipe #(.WIDTH(8), .ACC_EN(1'b0)) u_dutn (.clk(clk), .rst(rst), .bus(busn));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.op = '0; bus4.use_acc = 1'b0;
    bus4.out_ready = 1'b1;
    bus8.in_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.op = '0; bus8.use_acc = 1'b0;
    bus8.out_ready = 1'b1;
    busn.in_valid = 1'b0; busn.a = '0; busn.b = '0; busn.op = '0; busn.use_acc = 1'b0;
    busn.out_ready = 1'b1;
  endtask

  task automatic test_reset();
    idle_all();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus8.out_valid, bus8.in_ready, bus8.result, bus8.acc,
         bus8.carry, bus8.zero, bus8.negative, bus8.overflow} !== '0) begin
      failures++;
      $display("FAIL reset_outputs8 got valid=%0b ready=%0b res=%0h acc=%0h flags=%0b%0b%0b%0b exp all 0",
               bus8.out_valid, bus8.in_ready, bus8.result, bus8.acc,
               bus8.carry, bus8.zero, bus8.negative, bus8.overflow);
    end
    checks++;
    if ({bus4.out_valid, bus4.in_ready, bus4.result, bus4.acc} !== '0) begin
      failures++;
      $display("FAIL reset_outputs4 got valid=%0b ready=%0b res=%0h acc=%0h exp all 0",
               bus4.out_valid, bus4.in_ready, bus4.result, bus4.acc);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus8.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got=%0b exp=1", bus8.in_ready);
    end
  endtask

  // a=0101, b=0110 through every opcode; flags packed as {v,n,z,c}.
  task automatic test_opcodes();
    logic [3:0] exp_r [8];
    logic [3:0] exp_f [8];
    exp_r = '{4'hb, 4'hf, 4'h4, 4'h7, 4'h3, 4'ha, 4'ha, 4'h2};
    exp_f = '{4'b1100, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0001};
    bus4.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        bus4.in_valid = 1'b1; bus4.a = 4'h5; bus4.b = 4'h6; bus4.op = 3'(c);
        bus4.use_acc = 1'b0;
        checks++;
        if (bus4.in_ready !== 1'b1) begin
          failures++;
          $display("FAIL op_in_ready beat=%0d got=%0b exp=1", c, bus4.in_ready);
        end
      end else begin
        bus4.in_valid = 1'b0;
      end
      tick();
      checks++;
      if (c == 0 || c == 9) begin
        if (bus4.out_valid !== 1'b0) begin
          failures++;
          $display("FAIL op_latency cycle=%0d out_valid got=%0b exp=0", c, bus4.out_valid);
        end
      end else if (bus4.out_valid !== 1'b1 || bus4.result !== exp_r[c-1] ||
                   {bus4.overflow, bus4.negative, bus4.zero, bus4.carry} !== exp_f[c-1]) begin
        failures++;
        $display("FAIL op_%0d got valid=%0b res=%0b vnzc=%0b%0b%0b%0b exp valid=1 res=%0b vnzc=%0b",
                 c - 1, bus4.out_valid, bus4.result, bus4.overflow, bus4.negative, bus4.zero,
                 bus4.carry, exp_r[c-1], exp_f[c-1]);
      end
    end
  endtask

  task automatic test_add_boundaries();
    logic [7:0] va [2];
    logic [7:0] exp_r [2];
    logic [3:0] exp_f [2];
    va    = '{8'hff, 8'h7f};
    exp_r = '{8'h00, 8'h80};
    exp_f = '{4'b0011, 4'b1100};
    bus8.out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c < 2) begin
        bus8.in_valid = 1'b1; bus8.a = va[c]; bus8.b = 8'h01; bus8.op = 3'b000;
        bus8.use_acc = 1'b0;
      end else begin
        bus8.in_valid = 1'b0;
      end
      tick();
      if (c > 0) begin
        checks++;
        if (bus8.out_valid !== 1'b1 || bus8.result !== exp_r[c-1] ||
            {bus8.overflow, bus8.negative, bus8.zero, bus8.carry} !== exp_f[c-1]) begin
          failures++;
          $display("FAIL add_boundary_%0d got valid=%0b res=%0h vnzc=%0b%0b%0b%0b exp valid=1 res=%0h vnzc=%0b",
                   c - 1, bus8.out_valid, bus8.result, bus8.overflow, bus8.negative, bus8.zero,
                   bus8.carry, exp_r[c-1], exp_f[c-1]);
        end
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    bus8.out_ready = 1'b0;
    bus8.in_valid = 1'b1; bus8.a = 8'd10; bus8.b = 8'd20; bus8.op = 3'b000; bus8.use_acc = 1'b0;
    tick();
    bus8.a = 8'd50; bus8.b = 8'd8; bus8.op = 3'b001;
    checks++;
    if (bus8.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_second_accept got=%0b exp=1", bus8.in_ready);
    end
    tick();
    bus8.a = 8'hf0; bus8.b = 8'h0f; bus8.op = 3'b100;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus8.in_ready !== 1'b0 || bus8.out_valid !== 1'b1 || bus8.result !== 8'h1e ||
          {bus8.overflow, bus8.negative, bus8.zero, bus8.carry} !== 4'b0000) begin
        failures++;
        $display("FAIL bp_stall_hold cycle=%0d got ready=%0b valid=%0b res=%0h vnzc=%0b%0b%0b%0b exp ready=0 valid=1 res=1e vnzc=0000",
                 i, bus8.in_ready, bus8.out_valid, bus8.result, bus8.overflow, bus8.negative,
                 bus8.zero, bus8.carry);
      end
      tick();
    end
    bus8.out_ready = 1'b1;
    #1;
    checks++;
    if (bus8.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready got=%0b exp=1", bus8.in_ready);
    end
    tick();
    bus8.in_valid = 1'b0;
    checks++;
    if (bus8.out_valid !== 1'b1 || bus8.result !== 8'h2a ||
        {bus8.overflow, bus8.negative, bus8.zero, bus8.carry} !== 4'b0000) begin
      failures++;
      $display("FAIL bp_second_out got valid=%0b res=%0h exp valid=1 res=2a vnzc=0000",
               bus8.out_valid, bus8.result);
    end
    tick();
    checks++;
    if (bus8.out_valid !== 1'b1 || bus8.result !== 8'hff ||
        {bus8.overflow, bus8.negative, bus8.zero, bus8.carry} !== 4'b0100) begin
      failures++;
      $display("FAIL bp_third_out got valid=%0b res=%0h exp valid=1 res=ff vnzc=0100",
               bus8.out_valid, bus8.result);
    end
    tick();
    checks++;
    if (bus8.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_drain got valid=%0b exp=0", bus8.out_valid);
    end
  endtask

  task automatic test_acc_chain();
    logic [7:0] exp_r [3];
    exp_r = '{8'd3, 8'd6, 8'd9};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus8.out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c < 3) begin
        bus8.in_valid = 1'b1; bus8.a = 8'h55; bus8.b = 8'd3; bus8.op = 3'b000;
        bus8.use_acc = 1'b1;
      end else begin
        bus8.in_valid = 1'b0; bus8.use_acc = 1'b0;
      end
      tick();
      if (c > 0) begin
        checks++;
        if (bus8.out_valid !== 1'b1 || bus8.result !== exp_r[c-1] || bus8.acc !== exp_r[c-1]) begin
          failures++;
          $display("FAIL acc_chain_%0d got valid=%0b res=%0d acc=%0d exp valid=1 res=%0d acc=%0d",
                   c - 1, bus8.out_valid, bus8.result, bus8.acc, exp_r[c-1], exp_r[c-1]);
        end
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    bus8.out_ready = 1'b0;
    bus8.in_valid = 1'b1; bus8.a = 8'd7; bus8.b = 8'd9; bus8.op = 3'b000; bus8.use_acc = 1'b0;
    tick();
    bus8.a = 8'd1; bus8.b = 8'd1;
    tick();
    bus8.in_valid = 1'b0;
    checks++;
    if (bus8.out_valid !== 1'b1 || bus8.result !== 8'd16 || bus8.acc !== 8'd16) begin
      failures++;
      $display("FAIL rst_stall_pre got valid=%0b res=%0d acc=%0d exp valid=1 res=16 acc=16",
               bus8.out_valid, bus8.result, bus8.acc);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.acc !== 8'd0 || bus8.result !== 8'd0 ||
        bus8.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_stall_async got valid=%0b acc=%0d res=%0d ready=%0b exp 0 0 0 0",
               bus8.out_valid, bus8.acc, bus8.result, bus8.in_ready);
    end
    tick();
    rst = 1'b0;
    bus8.out_ready = 1'b1;
    #1;
    checks++;
    if (bus8.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_stall_ready got=%0b exp=1", bus8.in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus8.out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_stall_stale cycle=%0d got valid=%0b res=%0d exp valid=0",
                 i, bus8.out_valid, bus8.result);
      end
    end
  endtask

  task automatic test_acc_disabled();
    busn.out_ready = 1'b1;
    busn.in_valid = 1'b1; busn.a = 8'd2; busn.b = 8'd2; busn.op = 3'b000; busn.use_acc = 1'b1;
    tick();
    busn.in_valid = 1'b0;
    tick();
    checks++;
    if (busn.out_valid !== 1'b1 || busn.result !== 8'd4 || busn.acc !== 8'd0) begin
      failures++;
      $display("FAIL acc_disabled got valid=%0b res=%0d acc=%0d exp valid=1 res=4 acc=0",
               busn.out_valid, busn.result, busn.acc);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_opcodes();
    test_add_boundaries();
    test_backpressure();
    test_acc_chain();
    test_reset_mid_stall();
    test_acc_disabled();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
